// File: rtl/ex_hazard_ctrl_if.sv
// ID-stage to EX hazard controller bus: ID instruction fields and branch flush in,
// forwarding selects, stall and stall counter out.
interface ex_hazard_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_dest;
  logic             id_regwrite;
  logic             id_memread;
  logic             flush;
  logic [1:0]       forwardA;
  logic [1:0]       forwardB;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  // Pipeline side: presents the ID instruction, consumes the hazard decisions
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_regwrite, id_memread, flush,
    input  forwardA, forwardB, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_regwrite, id_memread, flush,
    output forwardA, forwardB, stall, stall_count
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: shadows ID/EX, EX/MEM and MEM/WB destinations, selects operand
// forwarding, stalls one cycle on load-use, squashes on flush and counts stall cycles.
module ex_hazard_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
) (
  input logic               clk,
  input logic               rst,
  ex_hazard_ctrl_if.slave   bus
);

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dest;
    logic             rw;
    logic             mr;
  } exSlot_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dest;
    logic             rw;
  } wrSlot_t;

  exSlot_t          exSlot;
  wrSlot_t          memSlot;
  wrSlot_t          wbSlot;
  logic [CNT_W-1:0] stallCount;

  logic             loadUse;
  logic             stallNow;
  logic             bubbleIn;
  logic [1:0]       fwdA;
  logic [1:0]       fwdB;

  // Select the newest in-flight writer of src; $0 is hardwired and never forwarded
  function automatic logic [1:0] fwdSel(
    input logic [REG_W-1:0] src,
    input wrSlot_t          mem,
    input wrSlot_t          wb
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (mem.v && mem.rw && (mem.dest != '0) && (mem.dest == src))
      sel = FWD_MEM;
    else if (wb.v && wb.rw && (wb.dest != '0) && (wb.dest == src))
      sel = FWD_WB;
    return sel;
  endfunction

  // Load in EX whose result the ID instruction needs next cycle; a taken branch overrides it
  always_comb begin
    loadUse = 1'b0;
    if (exSlot.v && exSlot.mr && exSlot.rw && (exSlot.dest != '0) && bus.id_valid) begin
      loadUse = (bus.id_uses_rs && (bus.id_rs == exSlot.dest)) ||
                (bus.id_uses_rt && (bus.id_rt == exSlot.dest));
    end
    stallNow = loadUse && !bus.flush;
    bubbleIn = bus.flush || stallNow || !bus.id_valid;
  end

  // Forwarding describes the instruction currently in EX; a bubble reads nothing
  always_comb begin
    fwdA = FWD_REG;
    fwdB = FWD_REG;
    if (exSlot.v) begin
      fwdA = fwdSel(exSlot.rs, memSlot, wbSlot);
      fwdB = fwdSel(exSlot.rt, memSlot, wbSlot);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exSlot  <= '0;
      memSlot <= '0;
      wbSlot  <= '0;
    end else begin
      memSlot <= '{v: exSlot.v, dest: exSlot.dest, rw: exSlot.rw};
      wbSlot  <= memSlot;
      if (bubbleIn) begin
        exSlot <= '0;
      end else begin
        exSlot <= '{v:    1'b1,
                    rs:   bus.id_rs,
                    rt:   bus.id_rt,
                    dest: bus.id_dest,
                    rw:   bus.id_regwrite,
                    mr:   bus.id_memread};
      end
    end
  end

  // Saturating performance counter of stalled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCount <= '0;
    end else if (stallNow && (stallCount != '1)) begin
      stallCount <= stallCount + CNT_W'(1);
    end
  end

  assign bus.forwardA    = fwdA;
  assign bus.forwardB    = fwdB;
  assign bus.stall       = stallNow;
  assign bus.stall_count = stallCount;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: directed pipeline scenarios plus randomized traffic
// compared each cycle against an instruction-history model.
module tb_ex_hazard_ctrl;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned CNT_W   = 6;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic             v;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dest;
    logic             rw;
    logic             mr;
  } instr_t;

  logic clk;
  logic rst;

  ex_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

  ex_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // hist[0] = instruction in EX, hist[1] = one stage older, hist[2] = two stages older
  instr_t hist [0:2];
  int     mCount;
  logic   obs;

  function automatic instr_t bubble();
    instr_t b;
    b.v = 1'b0; b.rs = '0; b.rt = '0; b.dest = '0; b.rw = 1'b0; b.mr = 1'b0;
    return b;
  endfunction

  // Newest older instruction that writes src supplies the operand
  function automatic logic [1:0] expFwd(input logic [REG_W-1:0] src);
    if (!hist[0].v || src == '0) return 2'b00;
    for (int age = 1; age <= 2; age++) begin
      if (hist[age].v && hist[age].rw && hist[age].dest == src)
        return (age == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) hist[i] = bubble();
    mCount = 0;
  endtask

  task automatic idleInputs();
    hz.id_valid = 1'b0; hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rs = 1'b0;
    hz.id_uses_rt = 1'b0; hz.id_dest = '0; hz.id_regwrite = 1'b0;
    hz.id_memread = 1'b0; hz.flush = 1'b0;
  endtask

  // One pipeline cycle: drive ID, compare all outputs to the model, advance on the clock edge
  task automatic step(input logic v, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                      input logic ur, input logic ut, input logic [REG_W-1:0] d,
                      input logic rw, input logic mr, input logic fl, output logic stObs);
    logic   expStall;
    instr_t cur;
    @(negedge clk);
    hz.id_valid = v; hz.id_rs = rs; hz.id_rt = rt; hz.id_uses_rs = ur; hz.id_uses_rt = ut;
    hz.id_dest = d; hz.id_regwrite = rw; hz.id_memread = mr; hz.flush = fl;
    #1;
    expStall = hist[0].v && hist[0].mr && hist[0].rw && hist[0].dest != '0 && v && !fl &&
               ((ur && rs == hist[0].dest) || (ut && rt == hist[0].dest));
    check("stall", 32'(hz.stall), 32'(expStall));
    check("forwardA", 32'(hz.forwardA), 32'(expFwd(hist[0].rs)));
    check("forwardB", 32'(hz.forwardB), 32'(expFwd(hist[0].rt)));
    check("stall_count", 32'(hz.stall_count), 32'(mCount));
    stObs = hz.stall;
    cur.v = 1'b1; cur.rs = rs; cur.rt = rt; cur.dest = d; cur.rw = rw; cur.mr = mr;
    @(posedge clk);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = (v && !fl && !expStall) ? cur : bubble();
    if (expStall && mCount < CNT_MAX) mCount++;
    #1;
  endtask

  task automatic alu(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                     input logic [REG_W-1:0] d, output logic stObs);
    step(1'b1, rs, rt, 1'b1, 1'b1, d, 1'b1, 1'b0, 1'b0, stObs);
  endtask

  task automatic nop(input int n);
    logic s;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, s);
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear immediately
  task automatic resetNow();
    rst = 1'b1;
    #1;
    check("rst_stall", 32'(hz.stall), 32'd0);
    check("rst_forwardA", 32'(hz.forwardA), 32'd0);
    check("rst_forwardB", 32'(hz.forwardB), 32'd0);
    check("rst_count", 32'(hz.stall_count), 32'd0);
    modelReset();
    idleInputs();
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    modelReset();
    repeat (2) @(negedge clk);
    check("init_stall", 32'(hz.stall), 32'd0);
    check("init_forwardA", 32'(hz.forwardA), 32'd0);
    check("init_count", 32'(hz.stall_count), 32'd0);
    #2 rst = 1'b0;

    // add $3,$1,$2 ; sub $4,$3,$5
    alu(5'd1, 5'd2, 5'd3, obs);
    alu(5'd3, 5'd5, 5'd4, obs);
    check("exmem_stall", 32'(obs), 32'd0);
    check("exmem_fwdA", 32'(hz.forwardA), 32'd2);
    check("exmem_fwdB", 32'(hz.forwardB), 32'd0);
    nop(3);

    // add $3 ; nop ; or $6,$7,$3
    alu(5'd1, 5'd2, 5'd3, obs);
    nop(1);
    alu(5'd7, 5'd3, 5'd6, obs);
    check("memwb_fwdA", 32'(hz.forwardA), 32'd0);
    check("memwb_fwdB", 32'(hz.forwardB), 32'd1);
    nop(3);

    // same with destination $0
    alu(5'd1, 5'd2, 5'd0, obs);
    nop(1);
    alu(5'd7, 5'd0, 5'd6, obs);
    check("r0_fwdB", 32'(hz.forwardB), 32'd0);
    nop(3);

    // lw $8,0($1) ; add $9,$8,$8
    @(negedge clk); #2; resetNow();
    step(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, obs);
    alu(5'd8, 5'd8, 5'd9, obs);
    check("lu_stall", 32'(obs), 32'd1);
    check("lu_bubble_fwdA", 32'(hz.forwardA), 32'd0);
    check("lu_count", 32'(hz.stall_count), 32'd1);
    alu(5'd8, 5'd8, 5'd9, obs);
    check("lu_release", 32'(obs), 32'd0);
    check("lu_fwdA", 32'(hz.forwardA), 32'd1);
    check("lu_fwdB", 32'(hz.forwardB), 32'd1);
    check("lu_count_hold", 32'(hz.stall_count), 32'd1);
    nop(3);

    // load-use with flush in the hazard cycle
    @(negedge clk); #2; resetNow();
    step(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, obs);
    step(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, obs);
    check("fl_stall", 32'(obs), 32'd0);
    check("fl_count", 32'(hz.stall_count), 32'd0);
    check("fl_bubble_fwdA", 32'(hz.forwardA), 32'd0);
    nop(3);

    // add $3 ; add $3 ; sub $4,$3,$3
    alu(5'd1, 5'd2, 5'd3, obs);
    alu(5'd5, 5'd6, 5'd3, obs);
    alu(5'd3, 5'd3, 5'd4, obs);
    check("prio_fwdA", 32'(hz.forwardA), 32'd2);
    check("prio_fwdB", 32'(hz.forwardB), 32'd2);
    nop(2);

    // reset while a load-use stall is asserted
    step(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, obs);
    @(negedge clk);
    hz.id_valid = 1'b1; hz.id_rs = 5'd8; hz.id_uses_rs = 1'b1; hz.id_dest = 5'd9;
    hz.id_regwrite = 1'b1;
    #1;
    check("midstall_pre", 32'(hz.stall), 32'd1);
    resetNow();

    // randomized traffic over a small register set to provoke hazards and counter saturation
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) resetNow();
      step($urandom_range(0, 7) != 0,
           REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           REG_W'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0, obs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
